// File: rtl/status_array_pkg.sv
// status_array_pkg
//   Definitions shared by the cache status blocks.
//   flush_state_e : flush FSM encoding (IDLE = 0, FLUSH = 1).
package status_array_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

endpackage : status_array_pkg

// File: rtl/status_array.sv
// status_array
//   DEPTH x WIDTH status array held in flops, with a per-bit masked write
//   port, a combinational read port and a flush engine that walks the whole
//   array clearing one entry per clock.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset (clears array, aborts flush)
//   addr_in    : entry index for both read and write
//   in         : write data
//   wmask      : per-bit write enable (1 = bit written)
//   wen        : write strobe (ignored while a flush walk runs)
//   flush_req  : start a flush walk (ignored while one is running)
//   out        : read data at addr_in (0 when out of range or flushing)
//   flush_busy : high while the flush walk is in progress
//   flush_done : one-cycle pulse after the last entry is cleared
module status_array
    import status_array_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    addr_in,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] wmask,
    input  logic             wen,
    input  logic             flush_req,
    output logic [WIDTH-1:0] out,
    output logic             flush_busy,
    output logic             flush_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    flush_state_e     state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Flops, not RAM: the synchronous clear of every entry rules out
    // block RAM inference.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             addr_valid;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data_d;

    // Widen by one bit so the compare is meaningful for power-of-two DEPTH
    // as well as for odd sizes where addr_in can exceed DEPTH-1.
    assign addr_valid = ({1'b0, addr_in} < DEPTH_W);

    // Writes only land in IDLE; a write during the walk is simply dropped.
    assign wr_en     = (state_q == IDLE) && wen && addr_valid;
    assign wr_data_d = (mem_q[addr_in] & ~wmask) | (in & wmask);

    // Flush FSM next state. The counter stops at LAST_IDX and is reloaded,
    // so it never leaves 0..DEPTH-1 for odd DEPTH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == FLUSH) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[addr_in] <= wr_data_d;
        end
    end

    // During the walk the array is half cleared; hide that by reading 0.
    assign out        = (busy_q || !addr_valid) ? '0 : mem_q[addr_in];
    assign flush_busy = busy_q;
    assign flush_done = done_q;

endmodule : status_array

// File: tb/tb_status_array.sv
module tb_status_array;

    logic clk;

    // Instance A: WIDTH=4, DEPTH=16
    logic       a_rst, a_wen, a_freq;
    logic [3:0] a_addr, a_in, a_wmask;
    logic [3:0] a_out;
    logic       a_busy, a_done;

    // Instance B: WIDTH=4, DEPTH=12
    logic       b_rst, b_wen, b_freq;
    logic [3:0] b_addr, b_in, b_wmask;
    logic [3:0] b_out;
    logic       b_busy, b_done;

    // Instance C: WIDTH=1, DEPTH=16
    logic       c_rst, c_wen, c_freq;
    logic [3:0] c_addr;
    logic [0:0] c_in, c_wmask;
    logic [0:0] c_out;
    logic       c_busy, c_done;

    int errors = 0;
    int checks = 0;

    status_array #(.WIDTH(4), .DEPTH(16)) u_a (
        .clk(clk), .rst(a_rst), .addr_in(a_addr), .in(a_in), .wmask(a_wmask),
        .wen(a_wen), .flush_req(a_freq), .out(a_out),
        .flush_busy(a_busy), .flush_done(a_done)
    );

    status_array #(.WIDTH(4), .DEPTH(12)) u_b (
        .clk(clk), .rst(b_rst), .addr_in(b_addr), .in(b_in), .wmask(b_wmask),
        .wen(b_wen), .flush_req(b_freq), .out(b_out),
        .flush_busy(b_busy), .flush_done(b_done)
    );

    status_array #(.WIDTH(1), .DEPTH(16)) u_c (
        .clk(clk), .rst(c_rst), .addr_in(c_addr), .in(c_in), .wmask(c_wmask),
        .wen(c_wen), .flush_req(c_freq), .out(c_out),
        .flush_busy(c_busy), .flush_done(c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1; b_rst = 1; c_rst = 1;
        tick(); tick();
        a_rst = 0; b_rst = 0; c_rst = 0;
        a_addr = 0; b_addr = 0; c_addr = 0;
        #1;
        checks++; if (a_out !== 4'h0) begin errors++; $display("FAIL reset_a_out got=%h exp=0", a_out); end
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL reset_a_flags busy=%b done=%b exp=0/0", a_busy, a_done); end
        checks++; if (b_busy !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL reset_b_flags busy=%b done=%b exp=0/0", b_busy, b_done); end
        checks++; if (c_busy !== 1'b0 || c_out !== 1'b0) begin errors++; $display("FAIL reset_c busy=%b out=%b exp=0/0", c_busy, c_out); end
        $display("reset: done");
    endtask

    task automatic test_masked_write();
        a_addr = 3; a_in = 4'hF; a_wmask = 4'hF; a_wen = 1;
        tick();
        a_wen = 0; #1;
        checks++; if (a_out !== 4'hF) begin errors++; $display("FAIL mask_full got=%h exp=F", a_out); end
        a_in = 4'h0; a_wmask = 4'h5; a_wen = 1; #1;
        // Before the edge the old value must still be visible (no bypass).
        checks++; if (a_out !== 4'hF) begin errors++; $display("FAIL no_bypass got=%h exp=F", a_out); end
        tick();
        a_wen = 0; #1;
        checks++; if (a_out !== 4'hA) begin errors++; $display("FAIL mask_partial got=%h exp=A", a_out); end
        $display("masked_write: addr3 out=%h", a_out);
    endtask

    task automatic test_flush_walk();
        a_in = 4'hF; a_wmask = 4'hF; a_wen = 1;
        for (int i = 0; i < 16; i++) begin
            a_addr = 4'(i);
            tick();
        end
        a_wen = 0;
        a_addr = 0; #1;
        checks++; if (a_out !== 4'hF) begin errors++; $display("FAIL fill_0 got=%h exp=F", a_out); end
        a_addr = 15; #1;
        checks++; if (a_out !== 4'hF) begin errors++; $display("FAIL fill_15 got=%h exp=F", a_out); end
        a_freq = 1;
        tick();                       // edge N
        a_freq = 0; a_addr = 4;
        for (int k = 0; k < 16; k++) begin
            checks++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL walk_busy k=%0d busy=%b done=%b exp=1/0", k, a_busy, a_done); end
            checks++; if (a_out !== 4'h0) begin errors++; $display("FAIL walk_out k=%0d got=%h exp=0", k, a_out); end
            tick();
        end
        // now just after edge N+16
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b1) begin errors++; $display("FAIL walk_end busy=%b done=%b exp=0/1", a_busy, a_done); end
        tick();
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL walk_done_pulse got=%b exp=0", a_done); end
        for (int i = 0; i < 16; i++) begin
            a_addr = 4'(i); #1;
            checks++; if (a_out !== 4'h0) begin errors++; $display("FAIL walk_clear addr=%0d got=%h exp=0", i, a_out); end
        end
        $display("flush_walk: complete");
    endtask

    task automatic test_flush_collision();
        a_addr = 5; a_in = 4'h9; a_wmask = 4'hF; a_wen = 1;
        tick();
        a_wen = 0; #1;
        checks++; if (a_out !== 4'h9) begin errors++; $display("FAIL coll_pre got=%h exp=9", a_out); end
        a_freq = 1;
        tick();                       // edge N
        a_freq = 0;
        a_in = 4'hF;
        for (int k = 0; k < 16; k++) begin
            checks++; if (a_busy !== 1'b1 || a_out !== 4'h0) begin errors++; $display("FAIL coll_busy k=%0d busy=%b out=%h exp=1/0", k, a_busy, a_out); end
            if (k == 8)  a_freq = 1;  // mid-walk request must not extend
            if (k == 10) a_wen = 1;   // lands after entry 5 was cleared
            tick();
            a_freq = 0; a_wen = 0;
        end
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b1) begin errors++; $display("FAIL coll_end busy=%b done=%b exp=0/1", a_busy, a_done); end
        checks++; if (a_out !== 4'h0) begin errors++; $display("FAIL coll_dropped got=%h exp=0", a_out); end
        tick();
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL coll_after busy=%b done=%b exp=0/0", a_busy, a_done); end
        $display("flush_collision: addr5 out=%h", a_out);
    endtask

    task automatic test_reset_mid_flush();
        bit done_seen;
        a_in = 4'hF; a_wmask = 4'hF; a_wen = 1;
        a_addr = 8;  tick();
        a_addr = 15; tick();
        a_wen = 0;
        a_freq = 1;
        tick();                       // edge N
        a_freq = 0;
        repeat (6) tick();            // edges N+1..N+6
        a_rst = 1;
        tick();                       // edge N+7
        a_rst = 0; #1;
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL rstmid_flags busy=%b done=%b exp=0/0", a_busy, a_done); end
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (a_done === 1'b1) done_seen = 1;
        end
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got=%b exp=0", done_seen); end
        a_addr = 8; #1;
        checks++; if (a_out !== 4'h0) begin errors++; $display("FAIL rstmid_8 got=%h exp=0", a_out); end
        a_addr = 15; #1;
        checks++; if (a_out !== 4'h0) begin errors++; $display("FAIL rstmid_15 got=%h exp=0", a_out); end
        $display("reset_mid_flush: done_seen=%b", done_seen);
    endtask

    task automatic test_odd_depth();
        int  cnt;
        bit  got;
        b_addr = 3; b_in = 4'h6; b_wmask = 4'hF; b_wen = 1;
        tick();
        b_addr = 13; b_in = 4'hF;
        tick();
        b_wen = 0; #1;
        checks++; if (b_out !== 4'h0) begin errors++; $display("FAIL odd_oob_out got=%h exp=0", b_out); end
        for (int i = 0; i < 12; i++) begin
            b_addr = 4'(i); #1;
            checks++;
            if (b_out !== ((i == 3) ? 4'h6 : 4'h0)) begin
                errors++; $display("FAIL odd_contents addr=%0d got=%h exp=%h", i, b_out, (i == 3) ? 4'h6 : 4'h0);
            end
        end
        // Two flushes back to back: the second is requested in the done cycle.
        b_addr = 3;
        b_freq = 1;
        for (int pass = 0; pass < 2; pass++) begin
            tick();                   // edge N
            b_freq = 0;
            checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL odd_start pass=%0d busy=%b exp=1", pass, b_busy); end
            cnt = 0; got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                if (b_busy === 1'b1) cnt++;
                if (b_done === 1'b1) got = 1;
                else tick();
            end
            checks++; if (got !== 1'b1 || cnt != 12) begin errors++; $display("FAIL odd_walk pass=%0d done=%b busy_cycles=%0d exp=1/12", pass, got, cnt); end
            checks++; if (b_out !== 4'h0) begin errors++; $display("FAIL odd_clear pass=%0d got=%h exp=0", pass, b_out); end
            $display("odd_depth: pass=%0d busy_cycles=%0d", pass, cnt);
            if (pass == 0) b_freq = 1;
        end
        tick();
        checks++; if (b_busy !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL odd_idle busy=%b done=%b exp=0/0", b_busy, b_done); end
    endtask

    task automatic test_simultaneous();
        c_addr = 2; c_in = 1'b1; c_wmask = 1'b1; c_wen = 1; c_freq = 1;
        tick();                       // edge N
        c_wen = 0; c_freq = 0;
        checks++; if (u_c.mem_q[2] !== 1'b1) begin errors++; $display("FAIL simul_written got=%b exp=1", u_c.mem_q[2]); end
        checks++; if (c_out !== 1'b0 || c_busy !== 1'b1) begin errors++; $display("FAIL simul_busy out=%b busy=%b exp=0/1", c_out, c_busy); end
        tick(); tick(); tick();       // edges N+1..N+3
        checks++; if (u_c.mem_q[2] !== 1'b0) begin errors++; $display("FAIL simul_cleared got=%b exp=0", u_c.mem_q[2]); end
        repeat (13) tick();           // through edge N+16
        checks++; if (c_done !== 1'b1 || c_out !== 1'b0) begin errors++; $display("FAIL simul_end done=%b out=%b exp=1/0", c_done, c_out); end
        $display("simultaneous: addr2 out=%b", c_out);
    endtask

    task automatic test_reset_priority();
        tick();
        c_addr = 4; c_in = 1'b1; c_wmask = 1'b1; c_wen = 1; c_freq = 1; c_rst = 1;
        tick();
        c_wen = 0; c_freq = 0; c_rst = 0; #1;
        checks++; if (c_busy !== 1'b0 || c_out !== 1'b0) begin errors++; $display("FAIL rst_prio busy=%b out=%b exp=0/0", c_busy, c_out); end
        $display("reset_priority: busy=%b out=%b", c_busy, c_out);
    endtask

    initial begin
        a_rst = 0; a_wen = 0; a_freq = 0; a_addr = 0; a_in = 0; a_wmask = 0;
        b_rst = 0; b_wen = 0; b_freq = 0; b_addr = 0; b_in = 0; b_wmask = 0;
        c_rst = 0; c_wen = 0; c_freq = 0; c_addr = 0; c_in = 0; c_wmask = 0;
        test_reset();
        test_masked_write();
        test_flush_walk();
        test_flush_collision();
        test_reset_mid_flush();
        test_odd_depth();
        test_simultaneous();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_status_array
